// File: rtl/md_hazard_ctrl.sv
// md_hazard_ctrl: issue gate and hazard controller in front of the
// multiply/divide unit. It squashes the E-stage HI/LO op on Req, mirrors md's
// busy window with its own countdown, and stalls D for any HI/LO user while
// md is occupied. It also keeps a sticky protocol-error flag and a saturating
// stall-cycle counter.
module md_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Req,
  input  logic             E_valid,
  input  logic [3:0]       E_HILOtype,
  input  logic [3:0]       D_HILOtype,
  output logic [3:0]       md_HILOtype,
  output logic             stall_D,
  output logic             md_busy,
  output logic [3:0]       md_cnt,
  output logic             err,
  output logic [CNT_W-1:0] stall_cycles
);

  // hilo_* codes shared with md (constants.v)
  localparam logic [3:0] HILO_NONE  = 4'd0;
  localparam logic [3:0] HILO_MULT  = 4'd1;
  localparam logic [3:0] HILO_MULTU = 4'd2;
  localparam logic [3:0] HILO_DIV   = 4'd3;
  localparam logic [3:0] HILO_DIVU  = 4'd4;
  localparam logic [3:0] HILO_MFHI  = 4'd5;
  localparam logic [3:0] HILO_MFLO  = 4'd6;
  localparam logic [3:0] HILO_MTHI  = 4'd7;
  localparam logic [3:0] HILO_MTLO  = 4'd8;
  localparam logic [3:0] HILO_MADD  = 4'd9;
  localparam logic [3:0] HILO_MADDU = 4'd10;
  localparam logic [3:0] HILO_MSUB  = 4'd11;
  localparam logic [3:0] HILO_MSUBU = 4'd12;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0]       MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0]       DIV_LOAD  = 4'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic is_div(input logic [3:0] t);
    return (t == HILO_DIV) || (t == HILO_DIVU);
  endfunction

  function automatic logic is_start(input logic [3:0] t);
    return is_div(t) || (t == HILO_MULT) || (t == HILO_MULTU) ||
           (t == HILO_MADD) || (t == HILO_MADDU) ||
           (t == HILO_MSUB) || (t == HILO_MSUBU);
  endfunction

  function automatic logic is_access(input logic [3:0] t);
    return (t == HILO_MFHI) || (t == HILO_MFLO) ||
           (t == HILO_MTHI) || (t == HILO_MTLO);
  endfunction

  logic [0:0] state;
  logic       e_start;
  logic       issue;

  // Squash the E-stage op on bubbles and on exception/interrupt entry.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    md_HILOtype = HILO_NONE;
    if (E_valid && !Req) md_HILOtype = E_HILOtype;
  end

  assign e_start = is_start(md_HILOtype);
  assign issue   = e_start && (state == S_IDLE);
  assign md_busy = (state == S_BUSY);
  assign stall_D = (is_start(D_HILOtype) || is_access(D_HILOtype)) &&
                   (e_start || md_busy);

  // Busy countdown: load on issue, count down to 1, then return to idle on
  // the edge where md commits HI/LO. In-flight ops survive Req.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state  <= S_IDLE;
      md_cnt <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            state  <= S_BUSY;
            md_cnt <= is_div(md_HILOtype) ? DIV_LOAD : MULT_LOAD;
          end
        end
        default: begin
          if (md_cnt > 4'd1) begin
            md_cnt <= md_cnt - 4'd1;
          end else begin
            state  <= S_IDLE;
            md_cnt <= 4'd0;
          end
        end
      endcase
    end
  end

  // Sticky flag: a START reached md while it was still busy.
  always_ff @(posedge clk) begin
    if (reset)                     err <= 1'b0;
    else if (e_start && md_busy)   err <= 1'b1;
  end

  // Saturating count of stalled D cycles.
  always_ff @(posedge clk) begin
    if (reset)                          stall_cycles <= '0;
    else if (stall_D && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_ONE;
  end

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Self-checking bench for md_hazard_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-indexed reference model that
// tracks the absolute cycle at which md finishes.
module tb_md_hazard_ctrl;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;
  localparam int CW     = 4;   // narrow counter so saturation is reachable

  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3,
                         DIVU = 4'd4, MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7,
                         MTLO = 4'd8, MADD = 4'd9, MADDU = 4'd10, MSUB = 4'd11,
                         MSUBU = 4'd12;

  logic          clk = 1'b0;
  logic          reset, Req, E_valid;
  logic [3:0]    E_HILOtype, D_HILOtype;
  logic [3:0]    md_HILOtype, md_cnt;
  logic          stall_D, md_busy, err;
  logic [CW-1:0] stall_cycles;

  md_hazard_ctrl #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Req(Req), .E_valid(E_valid),
    .E_HILOtype(E_HILOtype), .D_HILOtype(D_HILOtype),
    .md_HILOtype(md_HILOtype), .stall_D(stall_D), .md_busy(md_busy),
    .md_cnt(md_cnt), .err(err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: md is busy strictly before cycle done_cyc.
  int cyc      = 0;
  int done_cyc = 0;
  bit m_err    = 0;
  int m_stalls = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit f_start(input logic [3:0] t);
    return (t inside {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU});
  endfunction

  function automatic bit f_user(input logic [3:0] t);
    return f_start(t) || (t inside {MFHI, MFLO, MTHI, MTLO});
  endfunction

  // Apply one cycle of inputs, compare everything, then advance the model
  // past the following rising edge.
  task automatic cycle(input bit r, input bit rq, input bit ev,
                       input logic [3:0] e, input logic [3:0] d);
    int  rem;
    bit  st_eff;
    bit  exp_stall;
    @(negedge clk);
    reset = r; Req = rq; E_valid = ev; E_HILOtype = e; D_HILOtype = d;
    #1;
    rem       = (done_cyc > cyc) ? done_cyc - cyc : 0;
    st_eff    = ev && !rq && f_start(e);
    exp_stall = f_user(d) && (st_eff || rem > 0);
    check("md_HILOtype", int'(md_HILOtype), (ev && !rq) ? int'(e) : int'(NONE));
    check("stall_D", int'(stall_D), int'(exp_stall));
    check("md_busy", int'(md_busy), int'(rem > 0));
    check("md_cnt", int'(md_cnt), rem);
    check("err", int'(err), int'(m_err));
    check("stall_cycles", int'(stall_cycles), m_stalls);
    if (r) begin
      done_cyc = cyc + 1; m_err = 0; m_stalls = 0;
    end else begin
      if (st_eff && rem == 0) done_cyc = cyc + 1 + ((e inside {DIV, DIVU}) ? DIV_C : MULT_C);
      if (st_eff && rem > 0)  m_err = 1;
      if (exp_stall && m_stalls < (1 << CW) - 1) m_stalls++;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic [3:0] d);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, NONE, d);
  endtask

  initial begin
    reset = 1; Req = 0; E_valid = 0; E_HILOtype = NONE; D_HILOtype = NONE;
    repeat (2) @(posedge clk);
    // One checked reset cycle establishes the model baseline.
    cycle(1, 0, 0, NONE, NONE);

    // 1: mult with mflo waiting in D
    cycle(0, 0, 1, MULT, MFLO);
    idle(6, MFLO);
    check("t1_stall_cycles", int'(stall_cycles), 6);
    check("t1_idle_busy", int'(md_busy), 0);

    // 2: div with no HI/LO user in D
    cycle(1, 0, 0, NONE, NONE);
    cycle(0, 0, 1, DIV, NONE);
    idle(11, NONE);

    // 3: madd squashed by Req
    cycle(0, 1, 1, MADD, MFHI);
    idle(1, NONE);
    check("t3_busy", int'(md_busy), 0);

    // 4: div, Req at cycle 3 does not disturb the countdown
    cycle(0, 0, 1, DIVU, NONE);
    idle(2, NONE);
    cycle(0, 1, 1, MTLO, NONE);
    check("t4_cnt_at_req", int'(md_cnt), 8);
    idle(8, NONE);

    // 5: forced multu while md_cnt = 3
    cycle(0, 0, 1, MULT, NONE);
    idle(2, NONE);
    cycle(0, 0, 1, MULTU, NONE);
    idle(4, NONE);
    check("t5_err_sticky", int'(err), 1);

    // 6: reset mid-div, then a fresh mult
    cycle(0, 0, 1, DIV, MFLO);
    idle(1, MFLO);
    cycle(1, 0, 0, NONE, MFLO);
    idle(1, NONE);
    cycle(0, 0, 1, MSUBU, NONE);
    idle(6, NONE);

    // Saturation: keep mflo in D across two back-to-back divs
    cycle(0, 0, 1, DIV, MFLO);
    idle(10, MFLO);
    cycle(0, 0, 1, DIV, MFLO);
    idle(10, MFLO);
    check("sat_stall_cycles", int'(stall_cycles), (1 << CW) - 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bit r, rq, ev;
      logic [3:0] e, d;
      r  = ($urandom_range(0, 99) < 2);
      rq = ($urandom_range(0, 99) < 15);
      ev = ($urandom_range(0, 99) < 80);
      e  = 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : NONE;
      // Mostly respect the stall so err stays meaningful for a while.
      if (md_busy && f_start(e) && $urandom_range(0, 9) != 0) e = NONE;
      cycle(r, rq, ev, e, d);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
